// File: rtl/console_pkg.sv
// Shared definitions for the text console: FSM states, control codes and the
// default screen geometry also used by the character renderer.
package console_pkg;

  localparam int          DEF_COLS  = 64;
  localparam int          DEF_ROWS  = 37;
  localparam logic [7:0]  DEF_BLANK = 8'h20;

  localparam logic [7:0]  CC_BS = 8'h08;
  localparam logic [7:0]  CC_LF = 8'h0A;
  localparam logic [7:0]  CC_FF = 8'h0C;
  localparam logic [7:0]  CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    CLEAR_LAST
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Write side of the text-mode character buffer: places glyph codes at the
// cursor, interprets CR/LF/BS/FF, and clears or scrolls the screen in memory.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter int         ADDRW = 12,
  parameter logic [7:0] BLANK = DEF_BLANK,
  localparam int        COLW  = $clog2(COLS),
  localparam int        ROWW  = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [7:0]       mem_rdata,
  output logic [COLW-1:0]  cur_col,
  output logic [ROWW-1:0]  cur_row,
  output logic             busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int CNTW  = ADDRW + 1;

  generate
    if (CELLS > (2 ** ADDRW)) begin : g_bad_size
      $error("text_console_writer: ROWS*COLS exceeds the video memory address space");
    end
    if ((COLS & (COLS - 1)) != 0) begin : g_bad_cols
      $error("text_console_writer: COLS must be a power of two");
    end
  endgenerate

  state_t            state_reg;
  logic [COLW-1:0]   col_reg;
  logic [ROWW-1:0]   row_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic [CNTW-1:0]   cnt_inc;
  logic              cnt_last;

  logic [ADDRW-1:0]  cur_addr;
  logic              at_last_col;
  logic              at_last_row;

  logic [COLW-1:0]   col_next;
  logic [ROWW-1:0]   row_next;
  logic              wr_en_next;
  logic [ADDRW-1:0]  wr_addr_next;
  logic [7:0]        wr_data_next;
  logic              scroll_req;
  logic              clear_req;

  assign cur_addr    = ADDRW'(row_reg) * ADDRW'(COLS) + ADDRW'(col_reg);
  assign at_last_col = (col_reg == COLW'(COLS - 1));
  assign at_last_row = (row_reg == ROWW'(ROWS - 1));
  assign cnt_inc     = cnt_reg + CNTW'(1);
  assign cnt_last    = (cnt_reg == CNTW'(CELLS - 1));

  assign cur_col = col_reg;
  assign cur_row = row_reg;
  assign busy    = ~char_ready;

  // Decode of the byte offered in IDLE; only applied when it is accepted.
  always_comb begin
    col_next     = col_reg;
    row_next     = row_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = cur_addr;
    wr_data_next = BLANK;
    scroll_req   = 1'b0;
    clear_req    = 1'b0;
    if (is_printable(char_data)) begin
      wr_en_next   = 1'b1;
      wr_data_next = char_data;
      if (at_last_col) begin
        col_next = '0;
        if (at_last_row) scroll_req = 1'b1;
        else             row_next   = row_reg + ROWW'(1);
      end else begin
        col_next = col_reg + COLW'(1);
      end
    end else begin
      case (char_data)
        CC_CR: col_next = '0;
        CC_LF: begin
          col_next = '0;
          if (at_last_row) scroll_req = 1'b1;
          else             row_next   = row_reg + ROWW'(1);
        end
        CC_BS: begin
          wr_en_next = 1'b1;
          // Stepping back from column 0 lands on the last cell of the previous
          // row, which is simply the preceding linear address.
          if (col_reg != '0) begin
            col_next     = col_reg - COLW'(1);
            wr_addr_next = cur_addr - ADDRW'(1);
          end else if (row_reg != '0) begin
            col_next     = COLW'(COLS - 1);
            row_next     = row_reg - ROWW'(1);
            wr_addr_next = cur_addr - ADDRW'(1);
          end
        end
        CC_FF: begin
          col_next  = '0;
          row_next  = '0;
          clear_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= CLEAR;
      cnt_reg    <= '0;
      col_reg    <= '0;
      row_reg    <= '0;
      char_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= BLANK;
      mem_raddr  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (char_valid && char_ready) begin
            mem_we    <= wr_en_next;
            mem_waddr <= wr_addr_next;
            mem_wdata <= wr_data_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            if (clear_req) begin
              state_reg  <= CLEAR;
              cnt_reg    <= '0;
              char_ready <= 1'b0;
            end else if (scroll_req) begin
              // First source address goes out now so its data is back by SCROLL_WR.
              state_reg  <= SCROLL_RD;
              cnt_reg    <= CNTW'(COLS);
              mem_raddr  <= ADDRW'(COLS);
              char_ready <= 1'b0;
            end
          end
        end
        CLEAR: begin
          mem_we    <= 1'b1;
          mem_waddr <= cnt_reg[ADDRW-1:0];
          mem_wdata <= BLANK;
          if (cnt_last) begin
            state_reg  <= IDLE;
            char_ready <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        SCROLL_RD: begin
          state_reg <= SCROLL_WR;
        end
        SCROLL_WR: begin
          mem_we    <= 1'b1;
          mem_waddr <= cnt_reg[ADDRW-1:0] - ADDRW'(COLS);
          mem_wdata <= mem_rdata;
          if (cnt_last) begin
            state_reg <= CLEAR_LAST;
            cnt_reg   <= CNTW'((ROWS - 1) * COLS);
          end else begin
            state_reg <= SCROLL_RD;
            cnt_reg   <= cnt_inc;
            mem_raddr <= cnt_inc[ADDRW-1:0];
          end
        end
        CLEAR_LAST: begin
          mem_we    <= 1'b1;
          mem_waddr <= cnt_reg[ADDRW-1:0];
          mem_wdata <= BLANK;
          if (cnt_last) begin
            state_reg  <= IDLE;
            char_ready <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg  <= CLEAR;
          cnt_reg    <= '0;
          char_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
